instr_queue: RTL

Instruction queue (IQ) between the fetch/decode stage and dispatch. It accepts decoded control words and their RVFI debug words from fetch through the `IQ_2_IR` handshake (`ld_iq` / `iq_ack`). It buffers them in program order in a circular FIFO and presents the oldest entry to dispatch (reservation stations/ROB) with a valid/ready handshake. A branch-mispredict flush empties it in one cycle.

---
 rtl/instr_queue_pkg.sv | 47 ++++
 rtl/iq_2_ir.sv | 12 +
 rtl/iq_storage.sv | 36 +++
 rtl/instr_queue.sv | 138 +++++++++++++
 4 files changed

// File: rtl/instr_queue_pkg.sv
// Shared types for the instruction-queue slice: decoded control word,
// RVFI debug word, and the queue's own entry / occupancy types.

package tomasula_types;
   typedef enum logic [3:0] {
      ARITH,
      LUI,
      AUIPC,
      JAL,
      JALR,
      BRANCH,
      LOAD,
      STORE
   } op_t;

   typedef struct packed {
      op_t         op;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } control_word;
endpackage

package rv32i_types;
   typedef struct packed {
      logic [31:0] order;
      logic [31:0] inst;
      logic [31:0] pc_rdata;
   } rvfi_word;
endpackage

package instr_queue_pkg;
   // Occupancy view of the queue, tracked alongside the count.
   typedef enum logic [1:0] {
      OCC_EMPTY,
      OCC_PARTIAL,
      OCC_FULL
   } occ_state_e;

   // One stored slot: the decoded instruction plus its debug word.
   typedef struct packed {
      tomasula_types::control_word cw;
      rv32i_types::rvfi_word       rvfi;
   } iq_entry_t;
endpackage

// File: rtl/iq_2_ir.sv
// Fetch/decode to instruction-queue link. Fetch raises ld_iq with a stable
// control word and rvfi word and holds them until the queue acknowledges
// (the acknowledge travels on a separate queue output, iq_ack).

interface IQ_2_IR;
   logic                        ld_iq;
   tomasula_types::control_word control_word;
   rv32i_types::rvfi_word       rvfi;

   modport IQ_SIG (input ld_iq, input control_word, input rvfi);
   modport IR_SIG (output ld_iq, output control_word, output rvfi);
endinterface

// File: rtl/iq_storage.sv
// Entry array for the instruction queue: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.

module iq_storage
   import instr_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  iq_entry_t     wr_data,
   input  logic [AW-1:0] rd_addr,
   output iq_entry_t     rd_data
);

   iq_entry_t mem_q [DEPTH];
   iq_entry_t mem_d [DEPTH];

   // Next array contents: only the addressed slot changes on a write.
   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_addr] = wr_data;
      end
   end

   // Array register update.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/instr_queue.sv
// In-order instruction queue between fetch/decode and dispatch.
//
// Handshakes:
//   enqueue  : iq_ack = ld_iq & ~full & ~flush_ip (& ~rst); a word is written
//              on every edge where iq_ack is high. Fetch holds ld_iq and data
//              until it sees iq_ack. iq_ack never depends on dispatch_ready,
//              so a full queue refuses even when a dequeue happens that cycle.
//   dispatch : dispatch_valid = ~empty & ~flush_ip (& ~rst); the head is
//              consumed on every edge where dispatch_valid & dispatch_ready.
//              dispatch_cw/dispatch_rvfi always show the head slot.
// No bypass: a word enqueued in cycle N is first visible in cycle N+1.
// flush_ip and rst both discard all contents at the edge; rst wins.

module instr_queue
   import instr_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CW    = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   IQ_2_IR.IQ_SIG                      iq_ir_itf,
   output logic                        iq_ack,
   input  logic                        flush_ip,
   input  logic                        dispatch_ready,
   output logic                        dispatch_valid,
   output tomasula_types::control_word dispatch_cw,
   output rv32i_types::rvfi_word       dispatch_rvfi,
   output logic                        iq_empty,
   output logic                        iq_full,
   output logic [$clog2(DEPTH):0]      iq_count,
   output occ_state_e                  iq_state
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (CW < 1)) begin : g_bad_param
      $error("instr_queue: DEPTH must be a power of two >= 2 and CW >= 1");
   end

   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   occ_state_e       state_q, state_d;

   logic      enq;
   logic      deq;
   iq_entry_t wr_entry;
   iq_entry_t rd_entry;

   assign iq_empty       = (count_q == '0);
   assign iq_full        = (count_q == CNT_W'(DEPTH));
   assign iq_ack         = iq_ir_itf.ld_iq & ~iq_full & ~flush_ip & ~rst;
   assign dispatch_valid = ~iq_empty & ~flush_ip & ~rst;
   assign enq            = iq_ack;
   assign deq            = dispatch_valid & dispatch_ready;

   assign wr_entry = '{cw: iq_ir_itf.control_word, rvfi: iq_ir_itf.rvfi};

   iq_storage #(.DEPTH(DEPTH), .AW(AW)) u_storage (
      .clk     (clk),
      .wr_en   (enq),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_entry)
   );

   assign dispatch_cw   = rd_entry.cw;
   assign dispatch_rvfi = rd_entry.rvfi;
   assign iq_count      = count_q;
   assign iq_state      = state_q;

   // Pointer and count next-state; a flush discards everything at once.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_ip) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (enq && !deq) begin
            count_d = count_q + CNT_W'(1);
         end else if (deq && !enq) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // Occupancy FSM transitions, driven by the same enqueue/dequeue events.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         OCC_EMPTY: begin
            if (enq) state_d = OCC_PARTIAL;
         end
         OCC_PARTIAL: begin
            if (enq && !deq && (count_q == CNT_W'(DEPTH - 1))) begin
               state_d = OCC_FULL;
            end else if (deq && !enq && (count_q == CNT_W'(1))) begin
               state_d = OCC_EMPTY;
            end
         end
         OCC_FULL: begin
            if (deq) state_d = OCC_PARTIAL;
         end
         default: state_d = OCC_EMPTY;
      endcase
      if (flush_ip) begin
         state_d = OCC_EMPTY;
      end
   end

   // Control registers; synchronous reset has priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= OCC_EMPTY;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
      end
   end

endmodule
